// File: rtl/pmod_als_light_monitor.sv
// -----------------------------------------------------------------------------
// pmod_als_light_monitor
//
// Consumer stage for the PmodALS SPI receiver. Once per receiver frame period
// it samples the 16-bit frame and extracts the 8-bit light code. It keeps a
// boxcar average of the code over 2**AVG_LOG2 samples. It then classifies the
// ambient light as DARK or BRIGHT around thr_level, with a +/-HYST band.
// Every class change raises a level interrupt that stays up until acknowledged.
//
// Pipeline, counted from the tick cycle (period counter all-ones):
//   p1 : capture code, update sample ring, running sum and fill count
//   p2 : average = sum >> AVG_LOG2, window-full flag
//   p3 : hysteresis compare, class / interrupt update
//
// Parameters
//   PERIOD_W  tick every 2**PERIOD_W clocks
//   AVG_LOG2  window = 2**AVG_LOG2 samples (1..4)
//   HYST      hysteresis half-band (8-bit unsigned)
//
// Ports
//   clock      in   1   system clock
//   reset      in   1   synchronous, active-high reset
//   value      in   16  receiver frame; light code = value[12:5]
//   thr_level  in   8   DARK/BRIGHT threshold (quasi-static)
//   irq_ack    in   1   one-cycle pulse, clears irq
//   peak_clear in   1   (PMOD_ALS_PEAK_EN only) clear the peak hold
//   peak       out  8   (PMOD_ALS_PEAK_EN only) largest code since clear/reset
//   light      out  8   last raw light code
//   light_avg  out  8   windowed average
//   avg_valid  out  1   window has been filled since reset
//   dark       out  1   current class (1 = DARK)
//   irq        out  1   pending class-change interrupt (level)
//
// Build option
//   PMOD_ALS_PEAK_EN : adds the peak_clear / peak ports and the peak-hold
//                      register. When undefined, neither exists.
// -----------------------------------------------------------------------------
module pmod_als_light_monitor #(
    parameter int         PERIOD_W = 22,
    parameter int         AVG_LOG2 = 3,
    parameter logic [7:0] HYST     = 8'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [7:0]  thr_level,
    input  logic        irq_ack,
`ifdef PMOD_ALS_PEAK_EN
    input  logic        peak_clear,
    output logic [7:0]  peak,
`endif
    output logic [7:0]  light,
    output logic [7:0]  light_avg,
    output logic        avg_valid,
    output logic        dark,
    output logic        irq
);

    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = 8 + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

    // -------------------------------------------------------------------------
    // Threshold helpers: band edges clamp instead of wrapping.
    // -------------------------------------------------------------------------
    function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? 8'd0 : (a - b);
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // -------------------------------------------------------------------------
    // Period counter and tick
    // -------------------------------------------------------------------------
    logic [PERIOD_W-1:0] cnt_q;
    logic                tick;

    assign tick = &cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Only bits [12:5] of the frame carry the light code.
    logic [7:0] code_p0;
    logic       unused_frame_bits;

    assign code_p0           = value[12:5];
    assign unused_frame_bits = ^{value[15:13], value[4:0]};

    // -------------------------------------------------------------------------
    // Stage p1: sample ring, running sum, fill count
    // -------------------------------------------------------------------------
    logic [7:0]          light_q,  light_d;
    logic [7:0]          smp_q [DEPTH];
    logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [SUM_W-1:0]    sum_q,    sum_d;
    logic [FILL_W-1:0]   fill_q,   fill_d;
    logic                vld_p1_q;
    logic [7:0]          oldest;

    // The slot about to be overwritten holds the oldest sample in the window;
    // subtracting it keeps the sum exact without ever re-adding the ring.
    assign oldest = smp_q[wr_ptr_q];

    always_comb begin
        light_d  = light_q;
        wr_ptr_d = wr_ptr_q;
        sum_d    = sum_q;
        fill_d   = fill_q;
        if (tick) begin
            light_d  = code_p0;
            wr_ptr_d = wr_ptr_q + 1'b1;
            sum_d    = sum_q + {{AVG_LOG2{1'b0}}, code_p0} - {{AVG_LOG2{1'b0}}, oldest};
            fill_d   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            light_q  <= '0;
            wr_ptr_q <= '0;
            sum_q    <= '0;
            fill_q   <= '0;
            vld_p1_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                smp_q[i] <= '0;
            end
        end else begin
            light_q  <= light_d;
            wr_ptr_q <= wr_ptr_d;
            sum_q    <= sum_d;
            fill_q   <= fill_d;
            vld_p1_q <= tick;
            if (tick) begin
                smp_q[wr_ptr_q] <= code_p0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage p2: average and window-full flag
    // -------------------------------------------------------------------------
    logic [7:0] avg_q,   avg_d;
    logic       valid_q, valid_d;
    logic       vld_p2_q;

    always_comb begin
        avg_d   = avg_q;
        valid_d = valid_q;
        if (vld_p1_q) begin
            avg_d   = sum_q[SUM_W-1:AVG_LOG2];
            // Sticky: once the window has filled it stays valid until reset.
            valid_d = valid_q | (fill_q == FILL_FULL);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            avg_q    <= '0;
            valid_q  <= 1'b0;
            vld_p2_q <= 1'b0;
        end else begin
            avg_q    <= avg_d;
            valid_q  <= valid_d;
            vld_p2_q <= vld_p1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Stage p3: hysteresis classifier and interrupt
    // -------------------------------------------------------------------------
    logic [7:0] thr_lo, thr_hi;
    logic       dark_q, dark_d;
    logic       irq_q,  irq_d;
    logic       irq_set;

    assign thr_lo = sat_sub8(thr_level, HYST);
    assign thr_hi = sat_add8(thr_level, HYST);

    always_comb begin
        dark_d  = dark_q;
        irq_set = 1'b0;
        // Evaluated only on the single p3 cycle of each tick, and only once
        // the average is meaningful.
        if (vld_p2_q && valid_q) begin
            if (!dark_q && (avg_q < thr_lo)) begin
                dark_d  = 1'b1;
                irq_set = 1'b1;
            end else if (dark_q && (avg_q >= thr_hi)) begin
                dark_d  = 1'b0;
                irq_set = 1'b1;
            end
        end
        // A new event outranks an acknowledge arriving in the same cycle.
        irq_d = irq_set | (irq_q & ~irq_ack);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dark_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            dark_q <= dark_d;
            irq_q  <= irq_d;
        end
    end

`ifdef PMOD_ALS_PEAK_EN
    // -------------------------------------------------------------------------
    // Peak hold (aligned with p1)
    // -------------------------------------------------------------------------
    logic [7:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (peak_clear) begin
            // A clear that lands on a sample restarts the hold from that sample.
            peak_d = tick ? code_p0 : 8'd0;
        end else if (tick && (code_p0 > peak_q)) begin
            peak_d = code_p0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`endif

    assign light     = light_q;
    assign light_avg = avg_q;
    assign avg_valid = valid_q;
    assign dark      = dark_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_pmod_als_light_monitor.sv
// Directed bench for pmod_als_light_monitor with PERIOD_W=4, AVG_LOG2=2,
// HYST=4. Expected averages and classes are worked out by hand from the
// running window contents.
module tb_pmod_als_light_monitor;

    logic        clock;
    logic        reset;
    logic [15:0] value;
    logic [7:0]  thr_level;
    logic        irq_ack;
    logic [7:0]  light;
    logic [7:0]  light_avg;
    logic        avg_valid;
    logic        dark;
    logic        irq;
`ifdef PMOD_ALS_PEAK_EN
    logic        peak_clear;
    logic [7:0]  peak;
`endif

    int n_vec;
    int n_err;
    int ph;          // bench copy of the period counter
    int prev_light;
    int prev_dark;

    pmod_als_light_monitor #(
        .PERIOD_W (4),
        .AVG_LOG2 (2),
        .HYST     (8'd4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .value     (value),
        .thr_level (thr_level),
        .irq_ack   (irq_ack),
`ifdef PMOD_ALS_PEAK_EN
        .peak_clear(peak_clear),
        .peak      (peak),
`endif
        .light     (light),
        .light_avg (light_avg),
        .avg_valid (avg_valid),
        .dark      (dark),
        .irq       (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) ph = 0;
        else       ph = (ph + 1) % 16;
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_light"}, light, 0);
        chk({tag, "_avg"},   light_avg, 0);
        chk({tag, "_valid"}, avg_valid, 0);
        chk({tag, "_dark"},  dark, 0);
        chk({tag, "_irq"},   irq, 0);
`ifdef PMOD_ALS_PEAK_EN
        chk({tag, "_peak"},  peak, 0);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        prev_light = 0;
        prev_dark  = 0;
    endtask

    // Drives one sample through all three stages and checks each stage.
    task automatic do_tick(input int code, input int e_avg, input int e_valid,
                           input int e_dark, input int e_irq,
                           input bit ack_s3, input bit pclr);
        value = {3'b000, code[7:0], 5'b00000};
        for (int i = 0; i < 32 && ph != 15; i++) step();
        if (ph != 15) begin
            chk("tick_wait", ph, 15);
            n_err++;
            $display("FAIL tick_wait: bench counter lost, stopping");
            $fatal(1);
        end
        chk("light_hold", light, prev_light);
`ifdef PMOD_ALS_PEAK_EN
        peak_clear = pclr;
`endif
        step();
`ifdef PMOD_ALS_PEAK_EN
        peak_clear = 1'b0;
`endif
        chk("light", light, code);
        prev_light = code;
        step();
        chk("avg", light_avg, e_avg);
        chk("valid", avg_valid, e_valid);
        chk("dark_early", dark, prev_dark);
        irq_ack = ack_s3;
        step();
        irq_ack = 1'b0;
        chk("dark", dark, e_dark);
        chk("irq", irq, e_irq);
        prev_dark = e_dark;
    endtask

    task automatic ack_only(input int e_irq);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("ack", irq, e_irq);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        ph = 0;
        prev_light = 0;
        prev_dark = 0;
        reset = 1'b1;
        value = 16'h0C80;
        thr_level = 8'd100;
        irq_ack = 1'b0;
`ifdef PMOD_ALS_PEAK_EN
        peak_clear = 1'b0;
`endif
        step();
        do_reset();
        chk_zero("rst");

        // Fill at code 100; class must not move before the window is full.
        do_tick(100,  25, 0, 0, 0, 0, 0);
        do_tick(100,  50, 0, 0, 0, 0, 0);
        do_tick(100,  75, 0, 0, 0, 0, 0);
        do_tick(100, 100, 1, 0, 0, 0, 0);

        // Step down to 90: 97 holds, 95 < lo=96 goes DARK.
        do_tick(90, 97, 1, 0, 0, 0, 0);
        do_tick(90, 95, 1, 1, 1, 0, 0);
        do_tick(90, 92, 1, 1, 1, 0, 0);
        do_tick(90, 90, 1, 1, 1, 0, 0);
        ack_only(0);
        ack_only(0);

        // Back to 100: stays DARK (below hi=104).
        do_tick(100,  92, 1, 1, 0, 0, 0);
        do_tick(100,  95, 1, 1, 0, 0, 0);
        do_tick(100,  97, 1, 1, 0, 0, 0);
        do_tick(100, 100, 1, 1, 0, 0, 0);

        // Code 104: BRIGHT once average reaches hi=104.
        do_tick(104, 101, 1, 1, 0, 0, 0);
        do_tick(104, 102, 1, 1, 0, 0, 0);
        do_tick(104, 103, 1, 1, 0, 0, 0);
        do_tick(104, 104, 1, 0, 1, 0, 0);

        // irq pending; ack coincides with a new change -> stays set.
        do_tick(90, 100, 1, 0, 1, 0, 0);
        do_tick(90,  97, 1, 0, 1, 0, 0);
        do_tick(90,  93, 1, 1, 1, 1, 0);
        ack_only(0);
        do_tick(90,  90, 1, 1, 0, 0, 0);

        // thr=2: lo clamps to 0, hi=6. First sample flips to BRIGHT, then
        // average 0 never drops below lo.
        thr_level = 8'd2;
        do_tick(0, 67, 1, 0, 1, 0, 0);
        ack_only(0);
        do_tick(0, 45, 1, 0, 0, 0, 0);
        do_tick(0, 22, 1, 0, 0, 0, 0);
        do_tick(0,  0, 1, 0, 0, 0, 0);

        // thr=253: lo=249, hi clamps to 255. Only average 255 is BRIGHT.
        thr_level = 8'd253;
        do_tick(255,  63, 1, 1, 1, 0, 0);
        do_tick(255, 127, 1, 1, 1, 0, 0);
        do_tick(255, 191, 1, 1, 1, 0, 0);
        do_tick(255, 255, 1, 0, 1, 0, 0);

        // Reset mid-fill restarts the window from empty.
        thr_level = 8'd100;
        do_reset();
        chk_zero("rst2");
        do_tick(100, 25, 0, 0, 0, 0, 0);
        do_tick(100, 50, 0, 0, 0, 0, 0);
        do_reset();
        chk_zero("rst3");
        do_tick(100,  25, 0, 0, 0, 0, 0);
        do_tick(100,  50, 0, 0, 0, 0, 0);
        do_tick(100,  75, 0, 0, 0, 0, 0);
        do_tick(100, 100, 1, 0, 0, 0, 0);

`ifdef PMOD_ALS_PEAK_EN
        // thr=0 keeps the class BRIGHT so only the peak hold is exercised.
        thr_level = 8'd0;
        chk("peak_fill", peak, 100);
        peak_clear = 1'b1;
        step();
        peak_clear = 1'b0;
        chk("peak_clr0", peak, 0);
        do_tick(50,   87, 1, 0, 0, 0, 0);
        chk("peak_50", peak, 50);
        do_tick(200, 112, 1, 0, 0, 0, 0);
        chk("peak_200", peak, 200);
        do_tick(30,   95, 1, 0, 0, 0, 0);
        chk("peak_30", peak, 200);
        peak_clear = 1'b1;
        step();
        peak_clear = 1'b0;
        chk("peak_clr", peak, 0);
        do_tick(30, 77, 1, 0, 0, 0, 0);
        chk("peak_after_clr", peak, 30);
        do_tick(20, 70, 1, 0, 0, 0, 1);
        chk("peak_clr_tick", peak, 20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
